prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning instruction width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning fetch byte-address width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the word count (DEPTH = 2**DEPTH_LOG2, legal range 1..ADDR_W-1).
REQ-004 clock  in  1  single clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 iaddr  in  ADDR_W  fetch byte address, halfword-aligned; bit 0 ignored.
REQ-007 ird  in  1  fetch request.
REQ-008 idata  out  DATA_W  fetched instruction word.
REQ-009 ivalid  out  1  idata holds the word requested in the previous cycle.
REQ-010 busy  out  1  load in progress; CPU stalls fetch.
REQ-011 ld_start  in  1  begin program load at word 0.
REQ-012 ld_data  in  8  loader byte.
REQ-013 ld_valid  in  1  ld_data valid.
REQ-014 ld_last  in  1  qualifies final byte of the program.
REQ-015 ld_ready  out  1  block accepts a byte this cycle.
REQ-016 ld_done  out  1  one-cycle pulse, load complete.
REQ-017 ld_count  out  DEPTH_LOG2+1  words written by the current/last load.

Function
REQ-018 FSM states SHALL be RUN, LOAD, DONE; reset state RUN.
REQ-019 RUN: ird=1 SHALL give idata = mem[iaddr[DEPTH_LOG2:1]] and ivalid=1 on the next cycle (1-cycle latency); ird=0 gives ivalid=0 next cycle, idata held.
REQ-020 Any nonzero iaddr bit above DEPTH_LOG2 SHALL be out of range: idata=0, ivalid=1 next cycle.
REQ-021 RUN with ld_start=1 SHALL go to LOAD, clear word pointer, byte index, ld_count; ld_start beats ird same cycle (fetch dropped, ivalid=0 next cycle).
REQ-022 ld_start in LOAD or DONE SHALL be ignored.
REQ-023 LOAD: ld_ready=1, busy=1; ird ignored, ivalid=0, idata held.
REQ-024 Byte accepted only when ld_valid&ld_ready; bytes pack little-endian, first byte into idata bits [7:0].
REQ-025 Accepting byte DATA_W/8-1 of a word SHALL write the assembled word to mem[pointer] that edge, pointer+1, ld_count+1.
REQ-026 ld_last on a non-final byte of a word SHALL zero-fill the remaining bytes and write the word that edge.
REQ-027 Accepted byte with ld_last=1 SHALL go LOAD->DONE.
REQ-028 Writing word DEPTH-1 (memory full) SHALL go LOAD->DONE regardless of ld_last; no pointer wrap, no overwrite of word 0.
REQ-029 DONE SHALL last exactly one cycle: ld_done=1, busy=1, ld_ready=0; then RUN.
REQ-030 Words not written by a load SHALL keep prior contents.
REQ-031 ld_count SHALL hold its value in RUN until the next ld_start.
REQ-032 ld_ready SHALL be 0 in RUN and DONE; ld_valid there has no effect.

Reset
REQ-033 reset=1 SHALL on the next edge force RUN, idata=0, ivalid=0, busy=0, ld_ready=0, ld_done=0, ld_count=0, pointer=0, byte index=0.
REQ-034 reset SHALL NOT modify the memory array; mid-load reset discards only the partially assembled word, words already written stay.
REQ-035 reset SHALL take priority over ld_start, ird and ld_valid in the same cycle.

Verification
REQ-036 Load 4 bytes 03,62,... (words 0x6203, 0x0004... 2 words, ld_last on byte 4) -> ld_count=2, ld_done pulse 1 cycle after last byte, busy low afterwards.
REQ-037 After load, ird=1 with iaddr=0,2 on consecutive cycles -> idata 0x6203 then second word, each with ivalid=1 one cycle after request.
REQ-038 Load 16 bytes, ld_last never asserted (DEPTH=8) -> DONE after 16th byte, ld_count=8, 17th byte sees ld_ready=0, word 0 unchanged.
REQ-039 Load 3 bytes AA,BB,CC with ld_last on CC -> word1=0x00CC, ld_count=2; iaddr=0x0010 fetch -> idata=0, ivalid=1.
REQ-040 Reset after 3 bytes of new load -> RUN, ld_count=0, word0 holds new value, word1 holds previous value.
REQ-041 ld_start and ird same cycle in RUN -> LOAD entered, ivalid=0 next cycle; ld_start pulse during LOAD -> no pointer clear.

Source files
------------

// File: rtl/prog_mem.sv
// Program memory with a byte-serial loader; the CPU fetches halfword-addressed words
// with one cycle of latency and is stalled (busy) while a load is in progress.
module prog_mem #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     iaddr,
    input  logic                  ird,
    output logic [DATA_W-1:0]     idata,
    output logic                  ivalid,
    output logic                  busy,
    input  logic                  ld_start,
    input  logic [7:0]            ld_data,
    input  logic                  ld_valid,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic [DEPTH_LOG2:0]   ld_count
);

    localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {StRun, StLoad, StDone} state_e;

    state_e                  state;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   ptr;
    logic [BIDX_W-1:0]       bidx;
    logic [DATA_W-1:0]       asm_word;

    logic                    accept;
    logic                    word_end;
    logic                    full;
    logic [DATA_W-1:0]       word_next;
    logic [DEPTH_LOG2-1:0]   fetch_idx;
    logic                    fetch_oor;
    logic                    unused_iaddr0;

    assign unused_iaddr0 = iaddr[0];

    always_comb begin
        accept    = (state == StLoad) && ld_valid;
        // ld_last closes a partial word; the unfilled upper bytes of asm_word are already zero
        word_end  = accept && (ld_last || (bidx == BIDX_W'(NBYTES - 1)));
        full      = (ptr == DEPTH_LOG2'(DEPTH - 1));
        word_next = asm_word | (DATA_W'(ld_data) << (8 * bidx));
        fetch_idx = iaddr[DEPTH_LOG2:1];
        fetch_oor = (iaddr >> (DEPTH_LOG2 + 1)) != '0;
    end

    // The array has no reset so a reset mid-load keeps words already written.
    always_ff @(posedge clock) begin
        if (!reset && word_end) begin
            mem[ptr] <= word_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StRun;
            idata    <= '0;
            ivalid   <= 1'b0;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_count <= '0;
            ptr      <= '0;
            bidx     <= '0;
            asm_word <= '0;
        end else begin
            case (state)
                StRun: begin
                    if (ld_start) begin
                        state    <= StLoad;
                        busy     <= 1'b1;
                        ld_ready <= 1'b1;
                        ivalid   <= 1'b0;
                        ptr      <= '0;
                        bidx     <= '0;
                        asm_word <= '0;
                        ld_count <= '0;
                    end else begin
                        ivalid <= ird;
                        if (ird) begin
                            idata <= fetch_oor ? '0 : mem[fetch_idx];
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (word_end) begin
                            asm_word <= '0;
                            bidx     <= '0;
                            ld_count <= ld_count + 1'b1;
                            // Pointer parks on the last word when the memory fills
                            if (!full) begin
                                ptr <= ptr + 1'b1;
                            end
                            if (ld_last || full) begin
                                state    <= StDone;
                                ld_ready <= 1'b0;
                                ld_done  <= 1'b1;
                            end
                        end else begin
                            asm_word <= word_next;
                            bidx     <= bidx + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state   <= StRun;
                    busy    <= 1'b0;
                    ld_done <= 1'b0;
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a transaction-level model of memory contents and load progress,
// compared every cycle, plus hand-computed literal checks of the directed scenarios.
module tb_prog_mem;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned DL = 3;
    localparam int unsigned DEPTH = 2 ** DL;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] iaddr;
    logic          ird;
    logic [DW-1:0] idata;
    logic          ivalid;
    logic          busy;
    logic          ld_start;
    logic [7:0]    ld_data;
    logic          ld_valid;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic [DL:0]   ld_count;

    int errors = 0;
    int checks = 0;

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
        .clock    (clock),
        .reset    (reset),
        .iaddr    (iaddr),
        .ird      (ird),
        .idata    (idata),
        .ivalid   (ivalid),
        .busy     (busy),
        .ld_start (ld_start),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_count (ld_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the loader has collected so far, and what every word must hold.
    typedef enum int {MRun, MLoad, MDone} mode_e;
    mode_e      m_mode = MRun;
    bit         live = 1'b0;
    logic [DW-1:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    logic [7:0] m_bytes [$];
    int         m_ptr, m_count;
    logic [DW-1:0] e_idata;
    bit         e_known;
    logic       e_ivalid, e_busy, e_ready, e_done;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
    end

    always @(posedge clock) begin
        logic [DW-1:0] w;
        if (reset) begin
            live = 1'b1;
            m_mode = MRun;
            e_idata = '0; e_known = 1'b1;
            e_ivalid = 0; e_busy = 0; e_ready = 0; e_done = 0;
            m_count = 0; m_ptr = 0;
            m_bytes.delete();
        end else if (m_mode == MRun) begin
            if (ld_start) begin
                m_mode = MLoad; m_ptr = 0; m_count = 0; m_bytes.delete();
                e_ivalid = 0; e_busy = 1; e_ready = 1;
            end else if (ird) begin
                e_ivalid = 1;
                if ((iaddr >> (DL + 1)) != 0) begin
                    e_idata = '0; e_known = 1'b1;
                end else begin
                    e_idata = m_mem[iaddr[DL:1]]; e_known = m_known[iaddr[DL:1]];
                end
            end else begin
                e_ivalid = 0;
            end
        end else if (m_mode == MLoad) begin
            if (ld_valid) begin
                m_bytes.push_back(ld_data);
                if (m_bytes.size() == DW / 8 || ld_last) begin
                    w = '0;
                    foreach (m_bytes[k]) w[8*k +: 8] = m_bytes[k];
                    m_mem[m_ptr] = w; m_known[m_ptr] = 1'b1;
                    m_count++;
                    if (ld_last || m_ptr == int'(DEPTH) - 1) begin
                        m_mode = MDone; e_ready = 0; e_done = 1;
                    end
                    m_ptr++;
                    m_bytes.delete();
                end
            end
        end else begin
            m_mode = MRun; e_done = 0; e_busy = 0;
        end
    end

    always @(negedge clock) begin
        if (live) begin
            chk("ivalid", 32'(ivalid), 32'(e_ivalid));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ld_ready", 32'(ld_ready), 32'(e_ready));
            chk("ld_done", 32'(ld_done), 32'(e_done));
            chk("ld_count", 32'(ld_count), 32'(m_count));
            if (e_known) chk("idata", 32'(idata), 32'(e_idata));
        end
    end

    task automatic drive(input logic rst, input logic st, input logic v, input logic last,
                         input logic [7:0] d, input logic rd, input logic [AW-1:0] a);
        @(negedge clock);
        reset = rst; ld_start = st; ld_valid = v; ld_last = last; ld_data = d;
        ird = rd; iaddr = a;
    endtask

    task automatic idle();                          drive(0, 0, 0, 0, 8'h00, 0, '0); endtask
    task automatic start();                         drive(0, 1, 0, 0, 8'h00, 0, '0); endtask
    task automatic put(input logic [7:0] d, input logic last); drive(0, 0, 1, last, d, 0, '0); endtask
    task automatic fetch(input logic [AW-1:0] a);   drive(0, 0, 0, 0, 8'h00, 1, a); endtask

    initial begin
        reset = 1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0; ird = 0; iaddr = 0;
        drive(1, 0, 0, 0, 8'h00, 0, '0);
        drive(1, 0, 0, 0, 8'h00, 0, '0);
        idle();
        chk("reset_idata", 32'(idata), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Two-word load, with a stray byte in RUN that must be ignored
        put(8'h99, 1);
        start();
        put(8'h03, 0); put(8'h62, 0); put(8'h04, 0); put(8'h00, 1);
        idle();
        chk("load1_done", 32'(ld_done), 32'h1);
        chk("load1_count", 32'(ld_count), 32'h2);
        idle();
        chk("load1_busy_after", 32'(busy), 32'h0);

        fetch(16'h0000); fetch(16'h0002);
        chk("fetch_w0", 32'(idata), 32'h6203);
        idle();
        chk("fetch_w1", 32'(idata), 32'h0004);
        idle();
        chk("fetch_hold", 32'(idata), 32'h0004);

        // Fill the memory without ld_last; 17th byte lands in DONE
        start();
        for (int i = 0; i < 16; i++) put(8'(8'h10 + i), 0);
        put(8'hEE, 0);
        chk("full_ready", 32'(ld_ready), 32'h0);
        chk("full_done", 32'(ld_done), 32'h1);
        chk("full_count", 32'(ld_count), 32'h8);
        idle();
        fetch(16'h0000); fetch(16'h000E);
        chk("full_w0", 32'(idata), 32'h1110);
        idle();
        chk("full_w7", 32'(idata), 32'h1F1E);

        // Odd byte count zero-fills the last word; out-of-range fetch reads zero
        start();
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 1);
        idle();
        chk("odd_count", 32'(ld_count), 32'h2);
        idle();
        fetch(16'h0002); fetch(16'h0010);
        chk("odd_w1", 32'(idata), 32'h00CC);
        idle();
        chk("oor_idata", 32'(idata), 32'h0);
        chk("oor_ivalid", 32'(ivalid), 32'h1);
        fetch(16'h0004);
        idle();
        chk("odd_w2_kept", 32'(idata), 32'h1514);

        // Reset mid-load, colliding with start/fetch/byte
        start();
        put(8'h11, 0); put(8'h22, 0); put(8'h33, 0);
        drive(1, 1, 1, 1, 8'h44, 1, 16'h0002);
        idle();
        chk("rst_count", 32'(ld_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ivalid", 32'(ivalid), 32'h0);
        fetch(16'h0000); fetch(16'h0002);
        chk("rst_w0_new", 32'(idata), 32'h2211);
        idle();
        chk("rst_w1_old", 32'(idata), 32'h00CC);

        // ld_start beats ird; ld_start inside LOAD is ignored
        fetch(16'h0006);
        drive(0, 1, 0, 0, 8'h00, 1, 16'h0004);
        idle();
        chk("start_beats_ird", 32'(ivalid), 32'h0);
        chk("start_busy", 32'(busy), 32'h1);
        put(8'h55, 0);
        start();
        put(8'h66, 0); put(8'h77, 0); put(8'h88, 1);
        idle();
        chk("restart_count", 32'(ld_count), 32'h2);
        idle();
        fetch(16'h0000); fetch(16'h0002);
        chk("restart_w0", 32'(idata), 32'h6655);
        idle();
        chk("restart_w1", 32'(idata), 32'h8877);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
